// File: rtl/quadrature_feedback.sv
// Quadrature encoder decoder with periodic position/velocity snapshots for a control loop.
// Define ENCODER_INDEX_EN to add the enc_index input, which zeroes the count on its rising edge.
module quadrature_feedback #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enc_a,
    input  logic               enc_b,
`ifdef ENCODER_INDEX_EN
    input  logic               enc_index,
`endif
    input  logic               zero_position,
    input  logic [31:0]        update_period,
    output logic signed [31:0] position,
    output logic signed [31:0] velocity,
    output logic               controller_update,
    output logic [15:0]        error_count
);

    logic [SYNC_STAGES-1:0] sync_a_q, sync_b_q, fill_q;
    logic [1:0]             cur_ab, prev_ab_q, ab_diff;
    logic                   primed_q;
    logic                   step_up_q, step_dn_q, illegal_q;
    logic [31:0]            count_q, count_d, ref_q, ref_d, period_q, period_d;
    logic                   strobe, clear, index_rise;

    assign cur_ab  = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};
    assign ab_diff = cur_ab ^ prev_ab_q;

    // fill_q marks when the synchronizer holds a genuine post-reset sample.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_a_q <= '0;
            sync_b_q <= '0;
            fill_q   <= '0;
        end else begin
            sync_a_q <= {sync_a_q[SYNC_STAGES-2:0], enc_a};
            sync_b_q <= {sync_b_q[SYNC_STAGES-2:0], enc_b};
            fill_q   <= {fill_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // First real sample only seeds prev_ab_q; decoding starts on the sample after it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_ab_q <= 2'b00;
            primed_q  <= 1'b0;
            step_up_q <= 1'b0;
            step_dn_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            prev_ab_q <= cur_ab;
            primed_q  <= primed_q | fill_q[SYNC_STAGES-1];
            step_up_q <= primed_q && (^ab_diff) && (prev_ab_q[1] ^ cur_ab[0]);
            step_dn_q <= primed_q && (^ab_diff) && !(prev_ab_q[1] ^ cur_ab[0]);
            illegal_q <= primed_q && (&ab_diff);
        end
    end

`ifdef ENCODER_INDEX_EN
    logic [SYNC_STAGES-1:0] sync_i_q;
    logic                   index_prev_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_i_q     <= '0;
            index_prev_q <= 1'b0;
        end else begin
            sync_i_q     <= {sync_i_q[SYNC_STAGES-2:0], enc_index};
            index_prev_q <= sync_i_q[SYNC_STAGES-1];
        end
    end

    assign index_rise = sync_i_q[SYNC_STAGES-1] & ~index_prev_q;
`else
    assign index_rise = 1'b0;
`endif

    assign clear = zero_position | index_rise;

    // Lowering update_period below the current count forces an immediate strobe.
    assign strobe = (update_period != 32'd0) &&
                    (({1'b0, period_q} + 33'd1) >= {1'b0, update_period});

    always_comb begin
        period_d = period_q + 32'd1;
        if (update_period == 32'd0 || strobe) begin
            period_d = 32'd0;
        end

        count_d = count_q;
        if (clear) begin
            count_d = 32'd0;
        end else if (step_up_q) begin
            count_d = count_q + 32'd1;
        end else if (step_dn_q) begin
            count_d = count_q - 32'd1;
        end

        ref_d = ref_q;
        if (clear) begin
            ref_d = 32'd0;
        end else if (strobe) begin
            ref_d = count_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q           <= 32'd0;
            ref_q             <= 32'd0;
            period_q          <= 32'd0;
            position          <= 32'sd0;
            velocity          <= 32'sd0;
            controller_update <= 1'b0;
            error_count       <= 16'd0;
        end else begin
            count_q           <= count_d;
            ref_q             <= ref_d;
            period_q          <= period_d;
            controller_update <= strobe;
            if (strobe) begin
                position <= count_q;
                velocity <= count_q - ref_q;
            end
            if (illegal_q && error_count != 16'hFFFF) begin
                error_count <= error_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_quadrature_feedback.sv
// Scoreboard bench for quadrature_feedback: an event-scheduled reference model predicts each
// strobe; a separate monitor compares whenever controller_update fires.
module tb_quadrature_feedback;

    localparam int unsigned S = 2;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               enc_a = 1'b0;
    logic               enc_b = 1'b0;
`ifdef ENCODER_INDEX_EN
    logic               enc_index = 1'b0;
`endif
    logic               zero_position = 1'b0;
    logic [31:0]        update_period = 32'd0;
    logic signed [31:0] position;
    logic signed [31:0] velocity;
    logic               controller_update;
    logic [15:0]        error_count;

    quadrature_feedback #(.SYNC_STAGES(S)) dut (
        .clock            (clock),
        .reset            (reset),
        .enc_a            (enc_a),
        .enc_b            (enc_b),
`ifdef ENCODER_INDEX_EN
        .enc_index        (enc_index),
`endif
        .zero_position    (zero_position),
        .update_period    (update_period),
        .position         (position),
        .velocity         (velocity),
        .controller_update(controller_update),
        .error_count      (error_count)
    );

    always #5 clock = ~clock;

    // Pending effect on the count: lands at edge 'at'.
    typedef struct {
        int unsigned at;
        int          delta;
        bit          illegal;
        bit          zero;
    } ev_t;

    typedef struct {
        int unsigned cyc;
        logic [31:0] pos;
        logic [31:0] vel;
        logic [15:0] err;
    } exp_t;

    ev_t         pend[$];
    exp_t        sb[$];
    int unsigned cyc = 0;
    int unsigned n_rel = 0;
    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned strobes = 0;
    logic [31:0] m_count = 32'd0;
    logic [31:0] m_ref = 32'd0;
    int unsigned m_err = 0;
    int          gidx = 0;

    // Reference model, evaluated once per rising edge.
    function automatic void model_step();
        bit          zero;
        bit          strobe_now;
        int          delta;
        int unsigned nerr;
        exp_t        e;
        if (!reset) begin
            m_count = 32'd0;
            m_ref   = 32'd0;
            m_err   = 0;
            n_rel   = 0;
            pend.delete();
            return;
        end
        n_rel++;
        zero  = zero_position;
        delta = 0;
        nerr  = 0;
        for (int i = pend.size() - 1; i >= 0; i--) begin
            if (pend[i].at == cyc) begin
                zero  = zero | pend[i].zero;
                delta = delta + pend[i].delta;
                nerr  = nerr + int'(pend[i].illegal);
                pend.delete(i);
            end
        end
        strobe_now = (update_period != 0) && (n_rel % update_period == 0);
        e.cyc = cyc;
        e.pos = m_count;
        e.vel = m_count - m_ref;
        if (zero) m_ref = 32'd0;
        else if (strobe_now) m_ref = m_count;
        m_count = zero ? 32'd0 : m_count + 32'(delta);
        m_err   = (m_err + nerr > 65535) ? 65535 : m_err + nerr;
        e.err   = 16'(m_err);
        if (strobe_now) sb.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clock);
        cyc++;
        model_step();
        @(negedge clock);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] gray(input int i);
        case (i & 3)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    // d = +1 forward, -1 reverse, 2 = both channels flip (illegal).
    task automatic move(input int d);
        ev_t ev;
        gidx = gidx + d;
        {enc_a, enc_b} = gray(gidx);
        ev.at      = cyc + S + 2;
        ev.delta   = (d == 2) ? 0 : d;
        ev.illegal = (d == 2);
        ev.zero    = 1'b0;
        pend.push_back(ev);
    endtask

`ifdef ENCODER_INDEX_EN
    task automatic index_pulse();
        ev_t ev;
        enc_index  = 1'b1;
        ev.at      = cyc + S + 1;
        ev.delta   = 0;
        ev.illegal = 1'b0;
        ev.zero    = 1'b1;
        pend.push_back(ev);
        tick();
        tick();
        enc_index = 1'b0;
    endtask
`endif

    task automatic do_reset(input logic [31:0] p);
        #2 reset = 1'b0;
        update_period = p;
        tick();
        tick();
        reset = 1'b1;
        tick();
        tick();
    endtask

    task automatic wait_strobe(input int budget, output int waited);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!controller_update && waited < budget);
        if (!controller_update) begin
            tests++;
            fails++;
            $display("FAIL wait_strobe: no strobe within %0d clocks", budget);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset && controller_update) begin
                strobes++;
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL strobe_extra: strobe at cyc %0d, required none", cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != cyc || position !== e.pos || velocity !== e.vel ||
                        error_count !== e.err) begin
                        fails++;
                        $display("FAIL strobe_data: got cyc %0d pos %0d vel %0d err %0d, required cyc %0d pos %0d vel %0d err %0d",
                                 cyc, position, velocity, error_count,
                                 e.cyc, $signed(e.pos), $signed(e.vel), e.err);
                    end
                end
            end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
                tests++;
                fails++;
                e = sb.pop_front();
                $display("FAIL strobe_missing: no strobe at cyc %0d, required pos %0d vel %0d",
                         cyc, $signed(e.pos), $signed(e.vel));
            end
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL timeout: simulation did not finish, %0d tests run", tests);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int w;
        int unsigned r;
        int unsigned s0;

        // Outputs held at zero while reset is low.
        tick();
        check("rst_position", position, 32'd0);
        check("rst_velocity", velocity, 32'd0);
        check("rst_update", {31'd0, controller_update}, 32'd0);
        check("rst_errors", {16'd0, error_count}, 32'd0);

        // 40 forward steps, 10 clocks apart, period 100.
        do_reset(32'd100);
        for (int i = 0; i < 40; i++) begin
            move(1);
            repeat (10) tick();
        end
        check("fwd_position", position, 32'd40);
        check("fwd_velocity", velocity, 32'd10);

        // 25 reverse steps from zero.
        do_reset(32'd150);
        for (int i = 0; i < 25; i++) begin
            move(-1);
            repeat (4) tick();
        end
        wait_strobe(200, w);
        check("rev_position", position, 32'hFFFF_FFE7);
        check("rev_velocity", velocity, 32'hFFFF_FFE7);
        check("rev_errors", {16'd0, error_count}, 32'd0);

        // Random walk with occasional zeroing and illegal jumps.
        do_reset(32'($urandom_range(3, 40)));
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 11);
            if (r < 4) move(1);
            else if (r < 7) move(-1);
            else if (r == 7) begin
                zero_position = 1'b1;
                tick();
                zero_position = 1'b0;
            end else if (r == 8) move(2);
            tick();
        end
        repeat (60) tick();

        // Period of one strobes every clock.
        do_reset(32'd1);
        for (int i = 0; i < 20; i++) begin
            move(($urandom_range(0, 1) == 0) ? 1 : -1);
            tick();
            tick();
        end
        repeat (8) tick();

        // Period of zero never strobes.
        do_reset(32'd0);
        s0 = strobes;
        for (int i = 0; i < 10; i++) begin
            move(1);
            repeat (3) tick();
        end
        repeat (20) tick();
        check("no_strobe_p0", strobes - s0, 32'd0);

        // Wrap past 0x7FFFFFFF.
        do_reset(32'd20);
        force dut.count_q = 32'h7FFF_FFFE;
        m_count = 32'h7FFF_FFFE;
        tick();
        release dut.count_q;
        wait_strobe(40, w);
        move(1);
        tick();
        tick();
        move(1);
        tick();
        tick();
        move(1);
        wait_strobe(40, w);
        check("wrap_position", position, 32'h8000_0001);
        check("wrap_velocity", velocity, 32'd3);

        // zero_position and a step reach the counter on the same edge at count 50.
        do_reset(32'd200);
        for (int i = 0; i < 50; i++) begin
            move(1);
            tick();
            tick();
        end
        repeat (6) tick();
        move(1);
        repeat (S + 1) tick();
        zero_position = 1'b1;
        tick();
        zero_position = 1'b0;
        wait_strobe(300, w);
        check("zero_position", position, 32'd0);
        check("zero_velocity", velocity, 32'd0);

        // 70000 illegal jumps saturate the error counter without moving the position.
        do_reset(32'd8);
        for (int i = 0; i < 5; i++) begin
            move(1);
            tick();
            tick();
        end
        repeat (6) tick();
        for (int i = 0; i < 70000; i++) begin
            move(2);
            tick();
        end
        repeat (10) tick();
        check("err_saturated", {16'd0, error_count}, 32'd65535);
        check("err_position", position, 32'd5);

        // One-clock reset mid-period.
        wait_strobe(20, w);
        repeat (3) tick();
        #2 reset = 1'b0;
        #1;
        check("mid_rst_position", position, 32'd0);
        check("mid_rst_velocity", velocity, 32'd0);
        check("mid_rst_update", {31'd0, controller_update}, 32'd0);
        check("mid_rst_errors", {16'd0, error_count}, 32'd0);
        tick();
        reset = 1'b1;
        wait_strobe(20, w);
        check("first_strobe_delay", w, 32'd8);

`ifdef ENCODER_INDEX_EN
        // Index pulse at count 12.
        do_reset(32'd50);
        for (int i = 0; i < 12; i++) begin
            move(1);
            tick();
            tick();
        end
        repeat (6) tick();
        index_pulse();
        wait_strobe(60, w);
        check("index_position", position, 32'd0);
`endif

        repeat (2) tick();
        #1;
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
